// File: rtl/error_vector_writer.sv
// error_vector_writer: stores a run of signed error samples, tracks |e| sum/max, and exposes a sync read port
module error_vector_writer #(
  parameter int N_SAMPLES = 150,
  parameter int W = 20,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic [AW-1:0] count,
  output logic          done,
  output logic [W+AW-1:0] sum_abs,
  output logic [W-1:0]  max_abs,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0] mem [N_SAMPLES];
  logic xfer;
  logic [W-1:0] abs_in;
  assign in_ready = state == COLLECT;
  assign done = state == DONE;
  // transfer decode, magnitude (most-negative value maps to 2^(W-1) unsigned), next state; start overrides a same-cycle sample
  always_comb begin
    xfer = in_valid && state == COLLECT && !start;
    abs_in = in_data[W-1] ? -in_data : in_data;
    state_nxt = start ? COLLECT : (xfer && count == AW'(N_SAMPLES - 1)) ? DONE : state;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  // run counters and statistics, cleared by start
  always_ff @(posedge clk) begin
    if (rst || start) begin
      count <= '0;
      sum_abs <= '0;
      max_abs <= '0;
    end else if (xfer) begin
      count <= count + 1'b1;
      sum_abs <= sum_abs + (W+AW)'(abs_in);
      max_abs <= abs_in > max_abs ? abs_in : max_abs;
    end
  end
  // sample memory; never cleared, overwritten in sample order
  always_ff @(posedge clk) if (xfer && !rst) mem[count] <= in_data;
  // registered read port; out-of-range addresses read as zero, same-cycle write yields old word
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_addr < AW'(N_SAMPLES) ? mem[rd_addr] : '0;
    end
  end
endmodule
